edge_event_detector: RTL and testbench
======================================

Name: edge_event_detector

Overview:
Parametrised multi-channel edge detector, the successor to our single-channel rising-edge pulse block. Each channel has:
- an optional input synchroniser;
- per-channel edge mode (rise, fall, both, off);
- a one-cycle event pulse;
- a sticky event flag and a saturating event counter, both software-clearable.

Used by interconnect control and status logic to turn level signals (IRQs, handshake levels, error lines) into counted, latched events.

Parameters:
N_CH, 4, number of independent channels (>=1)
SYNC_STAGES, 2, synchroniser flops per channel before detection (0 = input used directly, for already-synchronous signals)
CNT_W, 8, width of each per-channel event counter (>=1)

Ports:
ACLK  input  1  clock; all logic on rising edge
ARESET  input  1  asynchronous reset, active-high
Sig_In  input  N_CH  monitored level signals, bit i = channel i
Mode  input  2*N_CH  per-channel mode, bits [2i+1:2i]: 00 off, 01 rising, 10 falling, 11 both
Clear  input  N_CH  per-channel clear strobe for sticky flag and counter, sampled each cycle
Edge_Pulse  output  N_CH  registered one-cycle event pulse per channel
Event_Sticky  output  N_CH  latched "event seen" flag per channel
Event_Cnt  output  N_CH*CNT_W  per-channel saturating event count, channel i at [i*CNT_W +: CNT_W]
Sync_Level  output  N_CH  synchronised/delayed level used for detection (prev-sample register)
Any_Event  output  1  OR of Edge_Pulse

Behaviour:
- Reset (ARESET high, async):
  - all synchroniser flops, prev-level register, Edge_Pulse, Event_Sticky and Event_Cnt go to 0 immediately.
  - Any_Event is therefore 0.
  - Holds while ARESET is high.
- Synchroniser:
  - s_i = Sig_In[i] delayed through SYNC_STAGES flops.
  - When SYNC_STAGES = 0, s_i = Sig_In[i] directly.
- Prev register: p_i <= s_i every cycle. Sync_Level[i] = p_i.
- Detection, per cycle:
  - rise = s_i & ~p_i; fall = ~s_i & p_i.
  - ev_i = (Mode01 & rise) | (Mode10 & fall) | (Mode11 & (rise|fall)); Mode00 gives 0.
  - Edge_Pulse[i] <= ev_i.
- Latency: if Sig_In[i] changes and is first sampled at edge n, Edge_Pulse[i] is high for exactly one cycle after edge n+SYNC_STAGES.
- Pulse width:
  - a level held for any duration gives exactly one pulse per transition.
  - alternating input every cycle in mode 11 gives Edge_Pulse high on consecutive cycles.
- Mode changes:
  - take effect on the cycle they are presented.
  - no pipeline flush; p_i keeps tracking in all modes, including 00.
  - enabling a mode therefore never produces a spurious pulse for a level that is already stable.
- Post-reset:
  - p_i resets to 0, so an input already high at reset release produces one rising event, at edge SYNC_STAGES after release plus the sync fill time.
  - This is required behaviour; falling mode produces no event in that case.
- Sticky flag: Event_Sticky[i] <= ev_i ? 1 : (Clear[i] ? 0 : Event_Sticky[i]). If event and clear occur in the same cycle, set wins.
- Counter:
  - on ev_i, Event_Cnt_i increments, saturating at 2^CNT_W-1 (no wrap).
  - Clear[i] alone loads 0.
  - Clear[i] together with ev_i loads 1.
  - Counter and sticky update on the same edge as Edge_Pulse.
- Any_Event: combinational OR of the registered Edge_Pulse bits; no extra latency.
- Reset mid-operation: state is discarded asynchronously; no pulse is emitted during or because of reset assertion.

Test Plan:
- Reset, then SYNC_STAGES=2, Mode=01 on ch0, raise Sig_In[0] before edge 10 -> Edge_Pulse[0] high only in the cycle after edge 12; Event_Cnt0=1; Event_Sticky[0]=1; Any_Event pulses once.
- Mode=11 on ch1, toggle Sig_In[1] every cycle for 6 cycles -> 6 consecutive Edge_Pulse[1] cycles; Event_Cnt1=6.
- Mode=10 on ch2, input high then low -> single pulse only on the falling transition; rising ignored; count=1.
- CNT_W=3, 9 rising events on ch3 -> count saturates at 7; Clear[3] asserted in the same cycle as a 10th event -> count=1 and sticky stays 1; next Clear alone -> count=0, sticky=0.
- Sig_In[0] high during reset, ARESET deasserts, Mode=01 -> exactly one pulse after sync fill; with Mode=00 -> no pulse, and a later switch to 01 while still high -> no pulse.
- ARESET asserted asynchronously mid-count on all channels -> all outputs 0 immediately, before the next ACLK edge.

Source files
------------

// File: rtl/edge_event_detector.sv
// edge_event_detector: multi-channel level-to-event converter.
// Each channel optionally synchronises its input and detects rising, falling or both edges
// under a per-channel mode. A detected edge produces a registered one-cycle pulse, sets a
// sticky flag and bumps a saturating counter. Software can clear the flag and the counter.
module edge_event_detector #(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic [N_CH-1:0]       Sig_In,
  input  logic [2*N_CH-1:0]     Mode,
  input  logic [N_CH-1:0]       Clear,
  output logic [N_CH-1:0]       Edge_Pulse,
  output logic [N_CH-1:0]       Event_Sticky,
  output logic [N_CH*CNT_W-1:0] Event_Cnt,
  output logic [N_CH-1:0]       Sync_Level,
  output logic                  Any_Event
);

  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic [N_CH-1:0]  sync_lvl;
  logic [N_CH-1:0]  prev_q;
  logic [N_CH-1:0]  rise, fall, ev;
  logic [N_CH-1:0]  pulse_q;
  logic [N_CH-1:0]  sticky_q, sticky_d;
  logic [CNT_W-1:0] cnt_q [N_CH];
  logic [CNT_W-1:0] cnt_d [N_CH];

  if (SYNC_STAGES == 0) begin : g_nosync
    // Input is already synchronous to ACLK; detect on it directly.
    assign sync_lvl = Sig_In;
  end else begin : g_sync
    logic [N_CH-1:0] stage_q [SYNC_STAGES];

    // Synchroniser shift chain, one vector per stage.
    always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
        stage_q <= '{default: '0};
      end else begin
        stage_q[0] <= Sig_In;
        for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
          stage_q[k] <= stage_q[k-1];
        end
      end
    end

    assign sync_lvl = stage_q[SYNC_STAGES-1];
  end

  assign rise = sync_lvl & ~prev_q;
  assign fall = ~sync_lvl & prev_q;

  // Per-channel mode select of the raw edge terms.
  always_comb begin
    ev = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      unique case (Mode[2*i +: 2])
        2'b00:   ev[i] = 1'b0;
        2'b01:   ev[i] = rise[i];
        2'b10:   ev[i] = fall[i];
        2'b11:   ev[i] = rise[i] | fall[i];
        default: ev[i] = 1'b0;
      endcase
    end
  end

  // Sticky flag and saturating counter next state; an event beats a same-cycle clear.
  always_comb begin
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    for (int unsigned i = 0; i < N_CH; i++) begin
      sticky_d[i] = ev[i] | (sticky_q[i] & ~Clear[i]);
      if (ev[i]) begin
        if (Clear[i]) begin
          cnt_d[i] = CntOne;
        end else if (cnt_q[i] != CntMax) begin
          cnt_d[i] = cnt_q[i] + CntOne;
        end
      end else if (Clear[i]) begin
        cnt_d[i] = '0;
      end
    end
  end

  // Previous-sample, pulse, sticky and counter state. The prev register tracks in every
  // mode so that enabling a mode on a stable level raises no event.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      prev_q   <= '0;
      pulse_q  <= '0;
      sticky_q <= '0;
      cnt_q    <= '{default: '0};
    end else begin
      prev_q   <= sync_lvl;
      pulse_q  <= ev;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  // Flatten the counters onto the output bus.
  always_comb begin
    Event_Cnt = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      Event_Cnt[i*CNT_W +: CNT_W] = cnt_q[i];
    end
  end

  assign Edge_Pulse   = pulse_q;
  assign Event_Sticky = sticky_q;
  assign Sync_Level   = prev_q;
  assign Any_Event    = |pulse_q;

endmodule

// File: tb/tb_edge_event_detector.sv
// Directed bench for edge_event_detector (4 channels, 2 sync stages, 3-bit counters).
module tb_edge_event_detector;

  logic        ACLK;
  logic        ARESET;
  logic [3:0]  Sig_In;
  logic [7:0]  Mode;
  logic [3:0]  Clear;
  logic [3:0]  Edge_Pulse;
  logic [3:0]  Event_Sticky;
  logic [11:0] Event_Cnt;
  logic [3:0]  Sync_Level;
  logic        Any_Event;

  int n_checks = 0;
  int n_fail   = 0;

  edge_event_detector #(
    .N_CH        (4),
    .SYNC_STAGES (2),
    .CNT_W       (3)
  ) dut (
    .ACLK         (ACLK),
    .ARESET       (ARESET),
    .Sig_In       (Sig_In),
    .Mode         (Mode),
    .Clear        (Clear),
    .Edge_Pulse   (Edge_Pulse),
    .Event_Sticky (Event_Sticky),
    .Event_Cnt    (Event_Cnt),
    .Sync_Level   (Sync_Level),
    .Any_Event    (Any_Event)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic step(input int n);
    repeat (n) @(negedge ACLK);
  endtask

  task automatic test_reset;
    ARESET = 1'b1; Sig_In = '0; Mode = '0; Clear = '0;
    step(3);
    n_checks++; if (Edge_Pulse !== 4'h0)
      begin n_fail++; $display("FAIL reset_pulse got %h want 0", Edge_Pulse); end
    n_checks++; if (Event_Sticky !== 4'h0)
      begin n_fail++; $display("FAIL reset_sticky got %h want 0", Event_Sticky); end
    n_checks++; if (Event_Cnt !== 12'h000)
      begin n_fail++; $display("FAIL reset_cnt got %h want 0", Event_Cnt); end
    n_checks++; if (Sync_Level !== 4'h0)
      begin n_fail++; $display("FAIL reset_sync got %h want 0", Sync_Level); end
    n_checks++; if (Any_Event !== 1'b0)
      begin n_fail++; $display("FAIL reset_any got %b want 0", Any_Event); end
    ARESET = 1'b0;
    step(3);
  endtask

  task automatic test_rise_latency;
    int pulses;
    Mode = 8'b0000_0001;
    Sig_In[0] = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      step(1);
      n_checks++; if (Edge_Pulse[0] !== 1'(c == 3))
        begin n_fail++; $display("FAIL rise_pulse c=%0d got %b want %b", c, Edge_Pulse[0], c == 3); end
      n_checks++; if (Any_Event !== 1'(c == 3))
        begin n_fail++; $display("FAIL rise_any c=%0d got %b want %b", c, Any_Event, c == 3); end
    end
    n_checks++; if (Sync_Level[0] !== 1'b1)
      begin n_fail++; $display("FAIL rise_sync got %b want 1", Sync_Level[0]); end
    n_checks++; if (Event_Cnt[2:0] !== 3'd1)
      begin n_fail++; $display("FAIL rise_cnt got %0d want 1", Event_Cnt[2:0]); end
    n_checks++; if (Event_Sticky[0] !== 1'b1)
      begin n_fail++; $display("FAIL rise_sticky got %b want 1", Event_Sticky[0]); end
    // Falling edge must be ignored in rising mode.
    Sig_In[0] = 1'b0;
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      step(1);
      if (Edge_Pulse[0]) pulses++;
    end
    n_checks++; if (pulses != 0)
      begin n_fail++; $display("FAIL rise_fall_ignored got %0d pulses want 0", pulses); end
    n_checks++; if (Event_Cnt[2:0] !== 3'd1)
      begin n_fail++; $display("FAIL rise_cnt_hold got %0d want 1", Event_Cnt[2:0]); end
    n_checks++; if (Sync_Level[0] !== 1'b0)
      begin n_fail++; $display("FAIL rise_sync_low got %b want 0", Sync_Level[0]); end
  endtask

  task automatic test_both;
    Mode = 8'b0000_1101;
    for (int c = 1; c <= 12; c++) begin
      if (c <= 6) Sig_In[1] = ~Sig_In[1];
      step(1);
      n_checks++; if (Edge_Pulse[1] !== 1'(c >= 3 && c <= 8))
        begin n_fail++;
          $display("FAIL both_pulse c=%0d got %b want %b", c, Edge_Pulse[1], c >= 3 && c <= 8); end
    end
    n_checks++; if (Event_Cnt[5:3] !== 3'd6)
      begin n_fail++; $display("FAIL both_cnt got %0d want 6", Event_Cnt[5:3]); end
    n_checks++; if (Event_Sticky[1] !== 1'b1)
      begin n_fail++; $display("FAIL both_sticky got %b want 1", Event_Sticky[1]); end
  endtask

  task automatic test_fall;
    int pulses;
    Mode = 8'b0010_1101;
    Sig_In[2] = 1'b1;
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      step(1);
      if (Edge_Pulse[2]) pulses++;
    end
    n_checks++; if (pulses != 0)
      begin n_fail++; $display("FAIL fall_rise_ignored got %0d pulses want 0", pulses); end
    n_checks++; if (Event_Cnt[8:6] !== 3'd0)
      begin n_fail++; $display("FAIL fall_cnt_pre got %0d want 0", Event_Cnt[8:6]); end
    Sig_In[2] = 1'b0;
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      step(1);
      if (Edge_Pulse[2]) pulses++;
    end
    n_checks++; if (pulses != 1)
      begin n_fail++; $display("FAIL fall_pulses got %0d want 1", pulses); end
    n_checks++; if (Event_Cnt[8:6] !== 3'd1)
      begin n_fail++; $display("FAIL fall_cnt got %0d want 1", Event_Cnt[8:6]); end
    n_checks++; if (Event_Sticky[2] !== 1'b1)
      begin n_fail++; $display("FAIL fall_sticky got %b want 1", Event_Sticky[2]); end
  endtask

  task automatic test_saturate_clear;
    Mode = 8'b0110_1101;
    for (int e = 0; e < 9; e++) begin
      Sig_In[3] = 1'b1; step(4);
      Sig_In[3] = 1'b0; step(4);
    end
    n_checks++; if (Event_Cnt[11:9] !== 3'd7)
      begin n_fail++; $display("FAIL sat_cnt got %0d want 7", Event_Cnt[11:9]); end
    n_checks++; if (Event_Sticky[3] !== 1'b1)
      begin n_fail++; $display("FAIL sat_sticky got %b want 1", Event_Sticky[3]); end
    // Tenth event lands on the same edge as a clear: set wins, counter loads 1.
    Sig_In[3] = 1'b1;
    step(2);
    Clear[3] = 1'b1;
    step(1);
    Clear[3] = 1'b0;
    n_checks++; if (Edge_Pulse[3] !== 1'b1)
      begin n_fail++; $display("FAIL clr_ev_pulse got %b want 1", Edge_Pulse[3]); end
    n_checks++; if (Event_Cnt[11:9] !== 3'd1)
      begin n_fail++; $display("FAIL clr_ev_cnt got %0d want 1", Event_Cnt[11:9]); end
    n_checks++; if (Event_Sticky[3] !== 1'b1)
      begin n_fail++; $display("FAIL clr_ev_sticky got %b want 1", Event_Sticky[3]); end
    step(2);
    Clear[3] = 1'b1;
    step(1);
    Clear[3] = 1'b0;
    n_checks++; if (Event_Cnt[11:9] !== 3'd0)
      begin n_fail++; $display("FAIL clr_cnt got %0d want 0", Event_Cnt[11:9]); end
    n_checks++; if (Event_Sticky !== 4'b0111)
      begin n_fail++; $display("FAIL clr_sticky got %b want 0111", Event_Sticky); end
    n_checks++; if (Event_Cnt[8:0] !== {3'd1, 3'd6, 3'd1})
      begin n_fail++; $display("FAIL clr_others got %h want %h", Event_Cnt[8:0], {3'd1, 3'd6, 3'd1}); end
    Sig_In[3] = 1'b0;
    step(4);
  endtask

  task automatic test_high_at_reset;
    int pulses;
    int anys;
    ARESET = 1'b1; Sig_In = 4'b0001; Mode = 8'h01; Clear = '0;
    step(2);
    n_checks++; if (Edge_Pulse !== 4'h0 || Sync_Level !== 4'h0)
      begin n_fail++; $display("FAIL hr_in_reset got p=%h s=%h want 0", Edge_Pulse, Sync_Level); end
    ARESET = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      step(1);
      n_checks++; if (Edge_Pulse[0] !== 1'(c == 3))
        begin n_fail++; $display("FAIL hr_pulse c=%0d got %b want %b", c, Edge_Pulse[0], c == 3); end
    end
    n_checks++; if (Event_Cnt[2:0] !== 3'd1)
      begin n_fail++; $display("FAIL hr_cnt got %0d want 1", Event_Cnt[2:0]); end
    // Same, but with the mode off: no event, and enabling later on a stable level is quiet.
    ARESET = 1'b1; Mode = 8'h00;
    step(2);
    ARESET = 1'b0;
    pulses = 0; anys = 0;
    for (int c = 0; c < 6; c++) begin
      step(1);
      if (Edge_Pulse[0]) pulses++;
      if (Any_Event) anys++;
    end
    n_checks++; if (pulses != 0 || anys != 0)
      begin n_fail++; $display("FAIL hr_off got %0d/%0d pulses want 0", pulses, anys); end
    Mode = 8'h01;
    pulses = 0;
    for (int c = 0; c < 5; c++) begin
      step(1);
      if (Edge_Pulse[0]) pulses++;
    end
    n_checks++; if (pulses != 0)
      begin n_fail++; $display("FAIL hr_enable got %0d pulses want 0", pulses); end
    n_checks++; if (Event_Cnt !== 12'h000 || Event_Sticky !== 4'h0)
      begin n_fail++; $display("FAIL hr_enable_state got c=%h s=%h want 0", Event_Cnt, Event_Sticky); end
    n_checks++; if (Sync_Level !== 4'b0001)
      begin n_fail++; $display("FAIL hr_sync got %b want 0001", Sync_Level); end
  endtask

  task automatic test_async_reset;
    Mode = 8'hFF;
    Sig_In = 4'b1110;
    step(3);
    n_checks++; if (Edge_Pulse !== 4'hF || Any_Event !== 1'b1)
      begin n_fail++; $display("FAIL ar_pre got p=%h a=%b want F/1", Edge_Pulse, Any_Event); end
    n_checks++; if (Event_Cnt !== {3'd1, 3'd1, 3'd1, 3'd1})
      begin n_fail++; $display("FAIL ar_pre_cnt got %h want %h", Event_Cnt, {3'd1, 3'd1, 3'd1, 3'd1}); end
    #2 ARESET = 1'b1;
    #1;
    n_checks++; if (Edge_Pulse !== 4'h0 || Any_Event !== 1'b0)
      begin n_fail++; $display("FAIL ar_pulse got p=%h a=%b want 0", Edge_Pulse, Any_Event); end
    n_checks++; if (Event_Sticky !== 4'h0 || Event_Cnt !== 12'h000 || Sync_Level !== 4'h0)
      begin n_fail++;
        $display("FAIL ar_state got s=%h c=%h l=%h want 0", Event_Sticky, Event_Cnt, Sync_Level); end
    step(2);
    n_checks++; if (Edge_Pulse !== 4'h0 || Event_Cnt !== 12'h000 || Sync_Level !== 4'h0)
      begin n_fail++;
        $display("FAIL ar_hold got p=%h c=%h l=%h want 0", Edge_Pulse, Event_Cnt, Sync_Level); end
    ARESET = 1'b0;
    step(1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_rise_latency();
    test_both();
    test_fall();
    test_saturate_clear();
    test_high_at_reset();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
